// File: rtl/axi_offset_update_ctrl_pkg.sv
// Shared definitions for the offset update controller: FSM encoding,
// AXI-Lite register word indices and register bit positions.
package axi_offset_update_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_e;

  // Word index of each register, taken from address bits [3:2]
  localparam logic [1:0] REG_CTRL       = 2'd0;
  localparam logic [1:0] REG_NEW_OFFSET = 2'd1;
  localparam logic [1:0] REG_STATUS     = 2'd2;
  localparam logic [1:0] REG_ACTIVE     = 2'd3;

  localparam int CTRL_START_BIT    = 0;
  localparam int STATUS_BUSY_BIT   = 0;
  localparam int STATUS_DONE_BIT   = 1;
  localparam int STATUS_RD_CNT_LSB = 8;
  localparam int STATUS_WR_CNT_LSB = 16;

endpackage

// File: rtl/axi_outstanding_counter.sv
// Saturating up/down count of outstanding transactions on one AXI channel,
// plus a flag marking a VALID that is presented downstream but not yet taken.
module axi_outstanding_counter #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 vld_out,
  input  logic                 rdy_in,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 busy,
  output logic                 at_max
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  // Next count: simultaneous inc/dec cancel; hold at both ends
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = vld_out && !rdy_in;
    if (inc && !dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count and busy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign cnt    = cnt_q;
  assign busy   = busy_q;
  assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/axi_offset_update_ctrl.sv
// Owns the base offset fed to the AXI master address adder. A software
// START fences new AR/AW handshakes, waits for outstanding traffic to
// drain, swaps in NEW_OFFSET and releases the fence.
//
// Handshake rule used on every channel here: a transfer happens in a cycle
// where VALID and READY are both high; VALID, once presented downstream,
// stays up until READY is seen (the fence never withdraws it).
module axi_offset_update_ctrl
  import axi_offset_update_ctrl_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH     = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH          = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            m_arvalid_in,
  output logic                            m_arready_out,
  output logic                            m_arvalid_out,
  input  logic                            m_arready_in,
  input  logic                            m_awvalid_in,
  output logic                            m_awready_out,
  output logic                            m_awvalid_out,
  input  logic                            m_awready_in,
  input  logic                            m_rvalid,
  input  logic                            m_rready,
  input  logic                            m_rlast,
  input  logic                            m_bvalid,
  input  logic                            m_bready,
  output logic [AXI_ADDR_WIDTH-1:0]       offset_out,
  output logic                            update_done_irq
);

  logic                          clk, rst_n;
  logic                          awready_q, awready_d, wready_q, wready_d;
  logic                          bvalid_q, bvalid_d, arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, rdata_mux;
  logic [AXI_ADDR_WIDTH-1:0]     new_offset_q, new_offset_d;
  logic [AXI_ADDR_WIDTH-1:0]     offset_q, offset_d;
  logic                          done_q, done_d, irq_q, irq_d;
  state_e                        state_q, state_d;
  logic                          wren, rden;
  logic [1:0]                    waddr, raddr;
  logic [CNT_WIDTH-1:0]          rd_cnt, wr_cnt;
  logic                          ar_busy, aw_busy, rd_full, wr_full;
  logic                          ar_block, aw_block, fenced, drain_ok;
  logic                          unused_ok;

  assign clk   = S_AXI_ACLK;
  assign rst_n = S_AXI_ARESETN;
  assign waddr = S_AXI_AWADDR[3:2];
  assign raddr = S_AXI_ARADDR[3:2];
  assign unused_ok = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                       S_AXI_AWPROT, S_AXI_ARPROT};

  // Fence: a channel with a stalled downstream VALID keeps passing until it
  // completes, so the in-flight request is counted before blocking starts.
  assign fenced        = (state_q != ST_IDLE);
  assign ar_block      = (fenced || rd_full) && !ar_busy;
  assign aw_block      = (fenced || wr_full) && !aw_busy;
  assign m_arvalid_out = m_arvalid_in && !ar_block;
  assign m_arready_out = m_arready_in && !ar_block;
  assign m_awvalid_out = m_awvalid_in && !aw_block;
  assign m_awready_out = m_awready_in && !aw_block;

  axi_outstanding_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (m_arvalid_out && m_arready_in),
    .dec     (m_rvalid && m_rready && m_rlast),
    .vld_out (m_arvalid_out),
    .rdy_in  (m_arready_in),
    .cnt     (rd_cnt),
    .busy    (ar_busy),
    .at_max  (rd_full)
  );

  axi_outstanding_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (m_awvalid_out && m_awready_in),
    .dec     (m_bvalid && m_bready),
    .vld_out (m_awvalid_out),
    .rdy_in  (m_awready_in),
    .cnt     (wr_cnt),
    .busy    (aw_busy),
    .at_max  (wr_full)
  );

  assign drain_ok = (rd_cnt == '0) && (wr_cnt == '0) && !ar_busy && !aw_busy;

  // Register read mux
  always_comb begin
    rdata_mux = '0;
    case (raddr)
      REG_NEW_OFFSET: rdata_mux[AXI_ADDR_WIDTH-1:0] = new_offset_q;
      REG_STATUS: begin
        rdata_mux[STATUS_BUSY_BIT]                 = fenced;
        rdata_mux[STATUS_DONE_BIT]                 = done_q;
        rdata_mux[STATUS_RD_CNT_LSB +: CNT_WIDTH]  = rd_cnt;
        rdata_mux[STATUS_WR_CNT_LSB +: CNT_WIDTH]  = wr_cnt;
      end
      REG_ACTIVE: rdata_mux[AXI_ADDR_WIDTH-1:0] = offset_q;
      default: rdata_mux = '0;
    endcase
  end

  // AXI-Lite handshakes, register writes and the update FSM next state
  always_comb begin
    // Address and data are taken together, one write outstanding at a time
    awready_d = !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
    wready_d  = awready_d;
    wren      = awready_q && wready_q && S_AXI_AWVALID && S_AXI_WVALID;
    bvalid_d  = bvalid_q;
    if (wren) begin
      bvalid_d = 1'b1;
    end else if (S_AXI_BREADY && bvalid_q) begin
      bvalid_d = 1'b0;
    end

    arready_d = !arready_q && S_AXI_ARVALID && !rvalid_q;
    rden      = arready_q && S_AXI_ARVALID;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (rden) begin
      rvalid_d = 1'b1;
      rdata_d  = rdata_mux;
    end else if (S_AXI_RREADY && rvalid_q) begin
      rvalid_d = 1'b0;
    end

    new_offset_d = new_offset_q;
    if (wren && (waddr == REG_NEW_OFFSET)) begin
      for (int b = 0; b < AXI_ADDR_WIDTH / 8; b++) begin
        if (S_AXI_WSTRB[b]) begin
          new_offset_d[b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
        end
      end
    end

    done_d = done_q;
    if (wren && (waddr == REG_STATUS) && S_AXI_WSTRB[0] &&
        S_AXI_WDATA[STATUS_DONE_BIT]) begin
      done_d = 1'b0;
    end

    state_d  = state_q;
    offset_d = offset_q;
    irq_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wren && (waddr == REG_CTRL) && S_AXI_WSTRB[0] &&
            S_AXI_WDATA[CTRL_START_BIT]) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_ok) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        offset_d = new_offset_q;
        done_d   = 1'b1;
        irq_d    = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All controller state, including the FSM and its registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      new_offset_q <= '0;
      offset_q     <= '0;
      done_q       <= 1'b0;
      irq_q        <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      new_offset_q <= new_offset_d;
      offset_q     <= offset_d;
      done_q       <= done_d;
      irq_q        <= irq_d;
      state_q      <= state_d;
    end
  end

  assign S_AXI_AWREADY   = awready_q;
  assign S_AXI_WREADY    = wready_q;
  assign S_AXI_BVALID    = bvalid_q;
  assign S_AXI_BRESP     = 2'b00;
  assign S_AXI_ARREADY   = arready_q;
  assign S_AXI_RVALID    = rvalid_q;
  assign S_AXI_RDATA     = rdata_q;
  assign S_AXI_RRESP     = 2'b00;
  assign offset_out      = offset_q;
  assign update_done_irq = irq_q;

endmodule
